// File: rtl/ncl_sync_source.sv
// Clocked-to-NCL boundary stage: issues binary words as alternating DATA/NULL dual-rail
// wavefronts, each paced by the synchronised completion of the downstream NCL stage.
module ncl_sync_source #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 init_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic [2*WIDTH-1:0]   z,
    input  logic                 zcomp,
    output logic [CNT_W-1:0]     tok_cnt,
    output logic                 proto_err
);

    // state     | meaning
    // WAIT_NULL | z is NULL, waiting for downstream to report NULL (zs==0)
    // IDLE      | z is NULL, ring empty, ready for the next word
    // WAIT_DATA | z holds DATA, waiting for downstream to report DATA (zs==1)
    typedef enum logic [1:0] {
        WAIT_NULL = 2'd0,
        IDLE      = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   zs, zs_q;
    logic [2*WIDTH-1:0]     z_nxt, enc;
    logic [CNT_W-1:0]       tok_nxt;
    logic                   err_nxt;

    assign zs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            sync_q <= '0;
            zs_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], zcomp};
            zs_q   <= zs;
        end
    end

    always_comb begin
        enc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            enc[2*i+1] = in_data[i];
            enc[2*i]   = ~in_data[i];
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state     <= WAIT_NULL;
            z         <= '0;
            tok_cnt   <= '0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            z         <= z_nxt;
            tok_cnt   <= tok_nxt;
            proto_err <= err_nxt;
        end
    end

    // Edge checks use the registered zs so a level held across states is not misread.
    always_comb begin
        state_nxt = state;
        z_nxt     = z;
        tok_nxt   = tok_cnt;
        err_nxt   = proto_err;
        in_ready  = 1'b0;
        case (state)
            WAIT_NULL: begin
                z_nxt = '0;
                if (!zs) state_nxt = IDLE;
            end
            IDLE: begin
                in_ready = ~zs;
                if (zs && !zs_q) err_nxt = 1'b1;
                if (in_valid && !zs) begin
                    z_nxt     = enc;
                    tok_nxt   = tok_cnt + CNT_W'(1);
                    state_nxt = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (!zs && zs_q) err_nxt = 1'b1;
                if (zs) begin
                    z_nxt     = '0;
                    state_nxt = WAIT_NULL;
                end
            end
            default: begin
                z_nxt     = '0;
                state_nxt = WAIT_NULL;
            end
        endcase
    end

endmodule

// File: tb/tb_ncl_sync_source.sv
// Scoreboard bench for ncl_sync_source: a behavioural NCL buffer answers the wavefronts,
// a monitor decodes each DATA wavefront and checks it against the words handed over.
module tb_ncl_sync_source;
    localparam int W = 4;
    localparam int S = 2;

    logic             clk = 1'b0;
    logic             init_n, in_valid, in_ready, in_ready2;
    logic [W-1:0]     in_data;
    logic [2*W-1:0]   z, z2;
    logic             zcomp, model_z, pulse_z, model_en;
    logic [15:0]      tok_cnt;
    logic [1:0]       tok_cnt2;
    logic             proto_err, proto_err2;

    int               n_cmp = 0;
    int               n_bad = 0;
    int               issued = 0;
    int               mon_tok = 0;
    logic [W-1:0]     exp_q[$];

    assign zcomp = model_z | pulse_z;
    always #5 clk = ~clk;

    ncl_sync_source #(.WIDTH(W), .SYNC_STAGES(S), .CNT_W(16)) dut (
        .clk(clk), .init_n(init_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .z(z), .zcomp(zcomp), .tok_cnt(tok_cnt), .proto_err(proto_err));

    ncl_sync_source #(.WIDTH(W), .SYNC_STAGES(S), .CNT_W(2)) dut2 (
        .clk(clk), .init_n(init_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .z(z2), .zcomp(zcomp), .tok_cnt(tok_cnt2), .proto_err(proto_err2));

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_data(logic [2*W-1:0] v);
        for (int i = 0; i < W; i++)
            if ((v[2*i] ^ v[2*i+1]) !== 1'b1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [W-1:0] decode(logic [2*W-1:0] v);
        logic [W-1:0] d;
        for (int i = 0; i < W; i++) d[i] = v[2*i+1];
        return d;
    endfunction

    // Behavioural NCL buffer: acknowledges a complete DATA or NULL after a random delay.
    initial begin
        model_z = 1'b0;
        forever begin
            @(negedge clk);
            if (!model_en) model_z = 1'b0;
            else if (!model_z && is_data(z)) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                model_z = 1'b1;
            end else if (model_z && z == '0) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                model_z = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic [2*W-1:0] prev;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!init_n) mon_tok = 0;
            if (z !== prev) begin
                check("dut2_z", z2, z);
                if (z != '0) begin
                    check("null_between", prev, 0);
                    check("one_hot", is_data(z), 1);
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_word: got %0h expected none", decode(z));
                    end else begin
                        check("word", decode(z), exp_q.pop_front());
                    end
                    mon_tok++;
                    check("tok_cnt", tok_cnt, mon_tok % 65536);
                    check("tok_cnt2", tok_cnt2, mon_tok % 4);
                end
            end
            prev = z;
        end
    end

    task automatic send(logic [W-1:0] w);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_data = w;
        for (int c = 0; c < 300 && !done; c++) begin
            if (in_ready) begin
                exp_q.push_back(w);
                issued++;
                done = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data = W'($urandom);
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: got no ready expected ready for word %0h", w);
        end
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && z == '0 && in_ready) done = 1'b1;
        end
        check("drain", done, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        init_n = 1'b0; in_valid = 1'b0; in_data = '0; pulse_z = 1'b0; model_en = 1'b0;
        #1;
        check("rst_z", z, 0);
        check("rst_ready", in_ready, 0);
        check("rst_tok", tok_cnt, 0);
        check("rst_err", proto_err, 0);
        repeat (3) @(negedge clk);
        init_n = 1'b1;
        for (k = 1; k < 10; k++) begin
            @(posedge clk); #1;
            if (in_ready) break;
        end
        check("ready_after_reset", k <= S + 1, 1);
        repeat (4) @(negedge clk);
        check("idle_null", z, 0);
        check("idle_ready", in_ready, 1);

        send(4'b1010);
        check("data_1010", z, 8'b10_01_10_01);
        check("tok_first", tok_cnt, 1);
        check("busy_ready", in_ready, 0);

        pulse_z = 1'b1;
        for (k = 1; k < 20; k++) begin
            @(posedge clk); #1;
            if (z == '0) break;
        end
        check("null_latency", k, S + 1);
        @(negedge clk);
        pulse_z = 1'b0;
        for (k = 1; k < 20; k++) begin
            @(posedge clk); #1;
            if (in_ready) break;
        end
        check("ready_latency", k, S + 1);
        @(negedge clk);

        model_en = 1'b1;
        for (int i = 0; i < 16; i++) send(W'(i));
        wait_drain();
        check("tok_stream", tok_cnt, issued);
        check("err_stream", proto_err, 0);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
            send(W'($urandom));
        end
        wait_drain();
        check("tok_random", tok_cnt, issued);
        check("err_random", proto_err, 0);

        model_en = 1'b0;
        pulse_z = 1'b1;
        repeat (S + 3) @(negedge clk);
        pulse_z = 1'b0;
        repeat (S + 3) @(negedge clk);
        check("err_set", proto_err, 1);
        model_en = 1'b1;
        send(W'($urandom));
        wait_drain();
        check("err_sticky", proto_err, 1);
        check("err_sticky2", proto_err2, 1);

        send(W'($urandom));
        #2;
        init_n = 1'b0;
        issued = 0;
        #1;
        check("mid_rst_z", z, 0);
        check("mid_rst_tok", tok_cnt, 0);
        check("mid_rst_tok2", tok_cnt2, 0);
        check("mid_rst_ready", in_ready, 0);
        repeat (10) @(negedge clk);
        init_n = 1'b1;
        check("rst_err_clear", proto_err, 0);
        for (int i = 0; i < 5; i++) send(W'($urandom));
        wait_drain();
        check("tok_five", tok_cnt, 5);
        check("tok2_wrap", tok_cnt2, 1);
        check("err_after", proto_err, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
